// File: rtl/alu_result_fifo.sv
// alu_result_fifo: captures {flag, result} pairs from the add/sub unit into a
// small show-ahead FIFO with a valid/ready output and overflow bookkeeping.
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_flag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_flag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Entry layout: flag in the MSB, result below it.
  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            overflow_reg;
  logic [7:0]      drop_count_reg;

  logic            pop;
  logic            push;
  logic            drop;
  logic [WIDTH:0]  head;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  // Storage array: written on push only, never reset (stale data stays hidden
  // behind the empty gate).
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_flag, in_result};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clear_ovf) begin
        drop_count_reg <= 8'd1;
      end else if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end else if (clear_ovf) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end
  end

  // Show-ahead head, gated to zero whenever nothing is stored.
  always_comb begin
    head       = mem[rd_ptr_reg];
    out_valid  = ~empty;
    out_result = '0;
    out_flag   = 1'b0;
    if (!empty) begin
      out_result = head[WIDTH-1:0];
      out_flag   = head[WIDTH];
    end
  end

  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: stimulus pushes expected entries into a
// queue, a negedge monitor pops and compares whenever the DUT hands one over.
module tb_alu_result_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_result;
  logic       in_flag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_flag;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_ovf;

  int n_vec  = 0;
  int n_fail = 0;

  logic [8:0] sb_q[$];
  int m_count = 0;

  alu_result_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_result(in_result), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flag(out_flag),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // One clock of stimulus; the expected entry is queued when the FIFO model
  // says the input will be accepted.
  task automatic step(input logic iv, input logic [7:0] r, input logic f,
                      input logic rdy, input logic clr);
    logic p_pop, p_push;
    in_valid  = iv;
    in_result = r;
    in_flag   = f;
    out_ready = rdy;
    clear_ovf = clr;
    p_pop  = (m_count > 0) && rdy;
    p_push = iv && ((m_count < 8) || p_pop);
    if (p_push) sb_q.push_back({f, r});
    @(posedge clock);
    #1;
    if (p_push && !p_pop) m_count++;
    else if (p_pop && !p_push) m_count--;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every accepted head entry must match the oldest queued value.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pop", {23'd0, out_flag, out_result}, 32'h1FF);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("pop_entry", {23'd0, out_flag, out_result}, {23'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_result = 0; in_flag = 0; out_ready = 0; clear_ovf = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle();

    // Asynchronous reset with five entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("pre_reset_count", count, 5);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_out_flag", out_flag, 0);
    sb_q.delete();
    m_count = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_result", out_result, 8'h3C);
    chk("post_rst_flag", out_flag, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("post_rst_drained", empty, 1);

    // Ordering and overflow.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'(i % 2), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_ovf_clear", overflow, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_drop3", drop_count, 3);
    chk("ovf_count", count, 8);
    chk("ovf_head", out_result, 8'h01);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Saturation and clear.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("sat_drop255", drop_count, 255);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_overflow", overflow, 0);
    chk("clr_drop", drop_count, 0);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("clr_drop_wins_ovf", overflow, 1);
    chk("clr_drop_wins_cnt", drop_count, 1);

    // Full pass-through across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'(i % 3 == 0), 1'b1, 1'b0);
      chk("pass_count", count, 8);
    end
    chk("pass_no_drop", drop_count, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pass_drained", empty, 1);

    // Streaming from empty.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h80 + 8'(i), 1'(i % 2), 1'b1, 1'b0);
      chk("stream_head", out_result, 8'h80 + i);
      chk("stream_count", count, 1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("stream_end_count", count, 0);
    chk("stream_drop", drop_count, 0);
    idle();
    chk("sb_leftover", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
